// File: rtl/load_store_unit.sv
// Memory-access stage: turns one RV32I load/store request into a word-aligned bus
// transaction and returns aligned, extended load data with a one-cycle response pulse.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS_REQ, S_BUS_RD, S_RESP} state_t;

    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offs_q;
    logic        we_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic        illegal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted_d;
    logic [31:0] rdata_d;
    logic        timeout_d;

    // Request legality plus store lane steering, evaluated on the incoming request.
    always_comb begin
        illegal_d = 1'b0;
        be_d      = 4'b0000;
        wdata_d   = 32'h0;
        if (req_we_i) begin
            if (req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11)) begin
                illegal_d = 1'b1;
            end
        end else begin
            if ((req_funct3_i[1:0] == 2'b11) || (req_funct3_i == 3'b110)) begin
                illegal_d = 1'b1;
            end
        end
        if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) begin
            illegal_d = 1'b1;
        end
        if ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00)) begin
            illegal_d = 1'b1;
        end
        case (req_funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << req_addr_i[1:0];
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata_i;
            end
        endcase
    end

    // Byte-lane extraction and sign/zero extension of the returned read word.
    always_comb begin
        shifted_d = mem_rdata_i >> {offs_q, 3'b000};
        case (funct3_q)
            3'b000:  rdata_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b100:  rdata_d = {24'h0, shifted_d[7:0]};
            3'b001:  rdata_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b101:  rdata_d = {16'h0, shifted_d[15:0]};
            default: rdata_d = shifted_d;
        endcase
        timeout_d = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TimeoutLimit);
    end

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'h0;
            funct3_q     <= 3'b000;
            offs_q       <= 2'b00;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        funct3_q    <= req_funct3_i;
                        offs_q      <= req_addr_i[1:0];
                        we_q        <= req_we_i;
                        req_ready_q <= 1'b0;
                        if (illegal_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= S_BUS_REQ;
                            cnt_q       <= 32'h0;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req_we_i;
                            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                            mem_be_q    <= req_we_i ? be_d : 4'b0000;
                            mem_wdata_q <= req_we_i ? wdata_d : 32'h0;
                        end
                    end
                end
                S_BUS_REQ: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        if (we_q) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= S_BUS_RD;
                        end
                    end else if (timeout_d) begin
                        mem_valid_q  <= 1'b0;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end
                end
                S_BUS_RD: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_rvalid_i) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= rdata_d;
                    end else if (timeout_d) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
